// File: rtl/sound_mixer_if.sv
// Mixer sample bus: per-channel samples, gains and mutes in; mixed sample out.
// Latency: n/a (wiring only).
// Backpressure: none; the mixer produces one sample per divider period.
interface sound_mixer_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS*16-1:0] ch_in;
  logic [CHANNELS*4-1:0]  ch_gain;
  logic [CHANNELS-1:0]    ch_mute;
  logic signed [15:0]     sample_out;
  logic                   sample_valid;
  logic                   clip;

  // Stimulus / upstream side: drives channel data, observes the mix
  modport master (
    output ch_in, ch_gain, ch_mute,
    input  sample_out, sample_valid, clip
  );

  // Mixer side
  modport slave (
    input  ch_in, ch_gain, ch_mute,
    output sample_out, sample_valid, clip
  );
endinterface

// File: rtl/sound_mixer.sv
// Gain/mute mixer: snapshots CHANNELS samples on a divider strobe, accumulates, saturates to 16 bits.
// Latency: CHANNELS+2 cycles strobe->sample_valid (CHANNELS+3 with SOUND_MIXER_LPF_EN for the one-pole filter).
// Backpressure: none; sample_valid is a one-cycle pulse, sample_out/clip hold until the next pulse.
module sound_mixer #(
  parameter int CHANNELS   = 4,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic         clk,
  input  logic         reset,
  sound_mixer_if.slave bus
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);

  // Reject illegal configurations at elaboration time
  generate
    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
      $error("sound_mixer: CHANNELS must be within 1..8");
    end
    if (SAMPLE_DIV < CHANNELS + 4) begin : g_bad_div
      $error("sound_mixer: SAMPLE_DIV must be at least CHANNELS+4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Divider and registered strobe
  logic [DIV_W-1:0] div_q, div_d;
  logic             strobe_q, strobe_d;

  // Snapshot of the inputs taken on strobe
  logic [CHANNELS*16-1:0] in_q;
  logic [CHANNELS*4-1:0]  gain_q;
  logic [CHANNELS-1:0]    mute_q;

  // Accumulation datapath
  logic [IDX_W-1:0]   idx_q;
  logic signed [23:0] acc_q;
  logic signed [15:0] cur_x;
  logic [3:0]         cur_g;
  logic               cur_m;
  logic signed [20:0] x_ext;
  logic signed [20:0] g_ext;
  logic signed [20:0] prod;
  logic signed [20:0] term;
  logic signed [23:0] term_ext;

  // Saturation result
  logic signed [15:0] sat_val;
  logic               sat_clip;

  // FSM controls
  logic snap_en;
  logic acc_en;
  logic sat_en;
  logic out_en;

  // Output registers
  logic signed [15:0] out_q;
  logic               clip_q;

  // Divider next-state: wraps at SAMPLE_DIV-1; the strobe is registered so the
  // first strobe lands SAMPLE_DIV cycles after the last reset edge
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    strobe_d = (div_q == DIV_LAST);
  end

  // Divider register
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      strobe_q <= strobe_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a strobe outside IDLE is simply not looked at
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (strobe_q) state_d = ACCUM;
      ACCUM:   if (idx_q == IDX_LAST) state_d = SAT;
      SAT:     state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: one control per stage
  always_comb begin
    snap_en = 1'b0;
    acc_en  = 1'b0;
    sat_en  = 1'b0;
    out_en  = 1'b0;
    case (state_q)
      IDLE:    snap_en = strobe_q;
      ACCUM:   acc_en  = 1'b1;
      SAT:     sat_en  = 1'b1;
      OUT:     out_en  = 1'b1;
      default: ;
    endcase
  end

  // Select the channel being accumulated this cycle from the snapshot
  always_comb begin
    cur_x = '0;
    cur_g = '0;
    cur_m = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_x = in_q[16*k +: 16];
        cur_g = gain_q[4*k +: 4];
        cur_m = mute_q[k];
      end
    end
  end

  // Per-channel term: signed sample times unsigned gain, floor-divided by 8
  always_comb begin
    x_ext    = {{5{cur_x[15]}}, cur_x};
    g_ext    = {17'b0, cur_g};
    prod     = x_ext * g_ext;
    term     = cur_m ? 21'sd0 : (prod >>> 3);
    term_ext = {{3{term[20]}}, term};
  end

  // Clamp the accumulator to the 16-bit signed range
  always_comb begin
    sat_val  = acc_q[15:0];
    sat_clip = 1'b0;
    if (acc_q > 24'sd32767) begin
      sat_val  = 16'sh7fff;
      sat_clip = 1'b1;
    end else if (acc_q < -24'sd32768) begin
      sat_val  = 16'sh8000;
      sat_clip = 1'b1;
    end
  end

  // Snapshot on strobe, then accumulate one channel per ACCUM cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q   <= '0;
      gain_q <= '0;
      mute_q <= '0;
      idx_q  <= '0;
      acc_q  <= '0;
    end else if (snap_en) begin
      in_q   <= bus.ch_in;
      gain_q <= bus.ch_gain;
      mute_q <= bus.ch_mute;
      idx_q  <= '0;
      acc_q  <= '0;
    end else if (acc_en) begin
      idx_q  <= idx_q + IDX_W'(1);
      acc_q  <= acc_q + term_ext;
    end
  end

`ifdef SOUND_MIXER_LPF_EN
  // Filter build: SAT result is staged, OUT applies y += (sat - y) >>> 2
  logic signed [15:0] sat_q;
  logic               sat_clip_q;
  logic               valid_q;
  logic signed [16:0] diff;
  logic signed [16:0] step;
  logic signed [15:0] y_d;

  // Filter step; the step never exceeds 16 bits and y stays between y and sat
  always_comb begin
    diff = {sat_q[15], sat_q} - {out_q[15], out_q};
    step = diff >>> 2;
    y_d  = out_q + step[15:0];
  end

  // Stage saturation in SAT, filter and pulse valid on leaving OUT
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_q      <= '0;
      sat_clip_q <= 1'b0;
      out_q      <= '0;
      clip_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= out_en;
      if (sat_en) begin
        sat_q      <= sat_val;
        sat_clip_q <= sat_clip;
      end
      if (out_en) begin
        out_q  <= y_d;
        clip_q <= sat_clip_q;
      end
    end
  end

  assign bus.sample_valid = valid_q;
`else
  // Direct build: saturated value lands in the output register entering OUT
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      clip_q <= 1'b0;
    end else if (sat_en) begin
      out_q  <= sat_val;
      clip_q <= sat_clip;
    end
  end

  assign bus.sample_valid = out_en;
`endif

  assign bus.sample_out = out_q;
  assign bus.clip       = clip_q;

endmodule

// File: tb/tb_sound_mixer.sv
// Directed bench for sound_mixer with CHANNELS=4, SAMPLE_DIV=16.
// Checks reset, first-sample latency, mixing, gain/mute, saturation, snapshot and abort.
// Sampling happens 1 time unit after each rising edge.
module tb_sound_mixer;

  localparam int CH  = 4;
  localparam int DIV = 16;
`ifdef SOUND_MIXER_LPF_EN
  localparam int LAT_FIRST = DIV + CH + 3;
`else
  localparam int LAT_FIRST = DIV + CH + 2;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  sound_mixer_if #(.CHANNELS(CH)) bus ();

  sound_mixer #(
    .CHANNELS   (CH),
    .SAMPLE_DIV (DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input int x, input int g, input bit m);
    logic [15:0] xs;
    logic [3:0]  gs;
    xs = 16'(x);
    gs = 4'(g);
    bus.ch_in[16*k +: 16] = xs;
    bus.ch_gain[4*k +: 4] = gs;
    bus.ch_mute[k]        = m;
  endtask

  // Step edges until sample_valid is seen or the budget runs out
  task automatic wait_valid(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.sample_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic expect_sample(input string tag, input int exp_out, input int exp_clip);
    int n;
    bit ok;
    wait_valid(40, n, ok);
    check({tag, "_valid"}, int'(ok), 1);
    check({tag, "_out"}, int'(bus.sample_out), exp_out);
    check({tag, "_clip"}, int'(bus.clip), exp_clip);
  endtask

  initial begin
    int n;
    bit ok;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.ch_in   = '0;
    bus.ch_gain = '0;
    bus.ch_mute = '0;
`ifdef SOUND_MIXER_LPF_EN
    for (int k = 0; k < CH; k++) set_ch(k, 0, 8, 1'b0);
`else
    set_ch(0, 1000, 8, 1'b0);
    set_ch(1, -200, 8, 1'b0);
    set_ch(2, 300, 8, 1'b0);
    set_ch(3, 0, 8, 1'b0);
`endif

    // Reset held for 3 edges
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", int'(bus.sample_out), 0);
    check("rst_valid", int'(bus.sample_valid), 0);
    check("rst_clip", int'(bus.clip), 0);
    reset = 1'b0;

    // First sample arrives DIV + latency edges after the last reset edge
    wait_valid(40, n, ok);
    check("first_seen", int'(ok), 1);
    check("first_lat", n, LAT_FIRST);
`ifdef SOUND_MIXER_LPF_EN
    check("first_out", int'(bus.sample_out), 0);
    @(posedge clk);
    #1;
    check("pulse_width", int'(bus.sample_valid), 0);

    // Step 0 -> 8000 through the one-pole filter
    set_ch(0, 8000, 8, 1'b0);
    expect_sample("lpf1", 2000, 0);
    expect_sample("lpf2", 3500, 0);
    wait_valid(40, n, ok);
    check("lpf_period", n, DIV);
    check("lpf3_out", int'(bus.sample_out), 4625);
`else
    check("unity_out", int'(bus.sample_out), 1100);
    check("unity_clip", int'(bus.clip), 0);
    @(posedge clk);
    #1;
    check("pulse_width", int'(bus.sample_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    check("hold_out", int'(bus.sample_out), 1100);

    // Gain and mute: 2000 + 7500 + 0 + (-1)
    set_ch(0, 4000, 4, 1'b0);
    set_ch(1, 4000, 15, 1'b0);
    set_ch(2, 4000, 8, 1'b1);
    set_ch(3, -1, 1, 1'b0);
    expect_sample("gainmute", 9499, 0);

    // Positive saturation
    for (int k = 0; k < CH; k++) set_ch(k, 30000, 8, 1'b0);
    expect_sample("satpos", 32767, 1);

    // Negative saturation
    for (int k = 0; k < CH; k++) set_ch(k, -30000, 8, 1'b0);
    expect_sample("satneg", -32768, 1);

    // Gain 15 floors toward -inf (-45/8 -> -6), gain 0 contributes nothing; clip clears
    set_ch(0, -3, 15, 1'b0);
    set_ch(1, 1234, 0, 1'b0);
    set_ch(2, 0, 8, 1'b0);
    set_ch(3, 0, 8, 1'b0);
    wait_valid(40, n, ok);
    check("floor_period", n, DIV);
    check("floor_out", int'(bus.sample_out), -6);
    check("floor_clip", int'(bus.clip), 0);

    // Snapshot: new inputs applied the cycle after the strobe must not leak in
    for (int k = 0; k < CH; k++) set_ch(k, 100, 8, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    for (int k = 0; k < CH; k++) set_ch(k, 5000, 8, 1'b0);
    expect_sample("snap_old", 400, 0);
    expect_sample("snap_new", 20000, 0);

    // Reset in the middle of ACCUM aborts that sample
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_out", int'(bus.sample_out), 0);
    check("abort_clip", int'(bus.clip), 0);
    reset = 1'b0;
    wait_valid(DIV + CH, n, ok);
    check("abort_novalid", int'(ok), 0);
    check("abort_hold_out", int'(bus.sample_out), 0);
    wait_valid(10, n, ok);
    check("restart_seen", int'(ok), 1);
    check("restart_lat", n + DIV + CH, LAT_FIRST);
    check("restart_out", int'(bus.sample_out), 20000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sound_mixer.md
SOUND_MIXER -- requirements
Module: sound_mixer

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, meaning the number of signed 16-bit sample inputs mixed (legal range 1..8).
REQ-002 The block SHALL have parameter SAMPLE_DIV, default 1000, meaning clk cycles per output sample (legal minimum CHANNELS+4).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port ch_in, input, CHANNELS*16 bits: signed per-channel samples, channel k at bits [16k+15:16k].
REQ-006 The block SHALL have port ch_gain, input, CHANNELS*4 bits: unsigned per-channel gain, channel k at [4k+3:4k]; 8 is unity.
REQ-007 The block SHALL have port ch_mute, input, CHANNELS bits: 1 forces the channel's contribution to 0.
REQ-008 The block SHALL have port sample_out, output, 16 bits: signed mixed sample.
REQ-009 The block SHALL have port sample_valid, output, 1 bit: one-cycle pulse when sample_out updates.
REQ-010 The block SHALL have port clip, output, 1 bit: high for the current sample_out if saturation occurred.

Function
REQ-011 A free-running divider SHALL count 0..SAMPLE_DIV-1 and assert an internal strobe for one cycle at count SAMPLE_DIV-1.
REQ-012 On strobe, ch_in, ch_gain and ch_mute SHALL be snapshotted in one cycle; later input changes SHALL NOT affect the sample in progress.
REQ-013 The FSM SHALL have states IDLE, ACCUM, SAT and OUT; IDLE->ACCUM on strobe, ACCUM->SAT after CHANNELS cycles, SAT->OUT, OUT->IDLE.
REQ-014 In ACCUM, one channel per cycle, in index order 0..CHANNELS-1: term = (ch_in * gain) arithmetic-shifted right by 3, added to a 24-bit signed accumulator cleared on strobe.
REQ-015 Muted channels SHALL add 0 and still consume their ACCUM cycle.
REQ-016 In SAT, the accumulator SHALL be clamped to [-32768, +32767]; clip is set if clamping changed the value, otherwise cleared.
REQ-017 In OUT, sample_out and clip SHALL update and sample_valid SHALL pulse high for exactly one cycle.
REQ-018 Latency SHALL be CHANNELS+2 cycles from the strobe cycle to the sample_valid cycle; with default CHANNELS=4, sample_valid occurs 6 cycles after strobe.
REQ-019 sample_out and clip SHALL hold their values between sample_valid pulses.
REQ-020 A strobe arriving outside IDLE SHALL be ignored; this is unreachable for legal SAMPLE_DIV.
REQ-021 Gain 0 SHALL yield a zero contribution; gain 15 SHALL yield x*15/8, floor-rounded via the arithmetic shift.

Reset
REQ-022 While reset is high on a clk edge, sample_out SHALL be 0, sample_valid 0, clip 0, the divider 0, the accumulator 0 and the FSM in IDLE.
REQ-023 Reset asserted mid-ACCUM SHALL abort the sample; no sample_valid SHALL follow for that sample.
REQ-024 After reset deasserts, the first strobe SHALL occur SAMPLE_DIV cycles later.

Configuration
REQ-025 With macro SOUND_MIXER_LPF_EN defined, the OUT value SHALL be filtered as y <= y + ((sat - y) >>> 2), with y 16-bit signed and reset to 0; this adds one pipeline cycle, so latency is CHANNELS+3.
REQ-026 Without SOUND_MIXER_LPF_EN defined, sample_out SHALL be the saturated value directly at latency CHANNELS+2, with no filter state.
REQ-027 clip SHALL reflect SAT-stage saturation in both builds.

Verification
REQ-028 Reset scenario: CHANNELS=4, SAMPLE_DIV=16, reset held 3 cycles -> all outputs 0; first sample_valid 16+6 cycles after reset release.
REQ-029 Unity sum scenario: ch_in = 1000, -200, 300, 0 with all gains 8 and no mute -> sample_out = 1100, clip = 0.
REQ-030 Gain and mute scenario: ch0 = 4000 at gain 4, ch1 = 4000 at gain 15, ch2 = 4000 muted, ch3 = -1 at gain 1 -> terms 2000 + 7500 + 0 + (-1) -> sample_out = 9499.
REQ-031 Saturation scenario: all four channels = 30000 at gain 8 -> sample_out = 32767 with clip = 1; all four = -30000 -> sample_out = -32768 with clip = 1.
REQ-032 Snapshot and reset scenario: change ch_in the cycle after strobe -> output uses the old values; reset during ACCUM -> no sample_valid, outputs 0.
REQ-033 LPF scenario (macro defined): step input 0 -> 8000 on ch0, gain 8 -> successive outputs 2000, 3500, 4625, with latency CHANNELS+3.
